mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 58 +++++
 rtl/mem_access_load_align.sv | 27 ++
 rtl/mem_access.sv | 141 ++++++++++++++
 tb/tb_mem_access.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared core constants: execute-stage widths, load/store func3 codes, LSU states
package mem_access_pkg;

  // Execute-stage datapath widths
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Load/store width and sign codes carried in func3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // True when a memory op has a known func3 for its direction and is naturally aligned
  function automatic logic access_legal(input logic ld, input logic st,
                                        input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    if (ld && !st) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    end else if (st && !ld) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    if (f3[1:0] == 2'b01 && a[0]) ok = 1'b0;
    if (f3[1:0] == 2'b10 && a != 2'b00) ok = 1'b0;
    return ok;
  endfunction

  // Byte enables for a store of the given width at byte offset a
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = 4'b0011 << a;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Store data replicated across every lane so the mask alone picks the bytes
  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// rtl/mem_access_load_align.sv - load lane select and sign/zero extension
module load_align
  import mem_access_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      lane_i,
  input  logic [2:0]      func3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half, then extend according to the load kind
  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = word_i[{lane_i[1], 4'b0000} +: 16];
    case (func3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access stage: ALU writeback pass-through and single-beat load/store bus master
module mem_access
  import mem_access_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        func3,
  input  logic [XLEN-1:0]   result_i,
  input  logic [XLEN-1:0]   store_data,
  input  logic [REG_AW-1:0] dest_i,
  output logic              stall_o,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_data,
  output logic [REG_AW-1:0] dest_o,
  output logic              mem_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_e        state_q, state_d;
  // data_q holds the ALU result / address after accept, then the read word after a load ack
  logic [XLEN-1:0]   data_q, data_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              we_q, we_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        f3_q, f3_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              alu_wb_q, alu_wb_d;
  logic              err_q, err_d;

  logic              accept;
  logic              is_mem;
  logic              legal;
  logic              in_req;
  logic              in_resp;
  logic [XLEN-1:0]   load_data;

  assign accept  = (state_q == ST_IDLE) && valid_i;
  assign is_mem  = is_load | is_store;
  assign legal   = access_legal(is_load, is_store, func3, result_i[1:0]);
  assign in_req  = (state_q == ST_REQ);
  assign in_resp = (state_q == ST_RESP);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: only legal memory ops leave IDLE; acks count only while requesting
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_mem && legal) state_d = ST_REQ;
      ST_REQ:  if (mem_ack) state_d = we_q ? ST_IDLE : ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the op on accept; overwrite the data slot with the read word on a load ack
  always_comb begin
    data_d   = data_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    we_d     = we_q;
    lane_d   = lane_q;
    f3_d     = f3_q;
    dest_d   = dest_q;
    alu_wb_d = 1'b0;
    err_d    = 1'b0;
    if (accept) begin
      data_d   = result_i;
      wdata_d  = store_lanes(func3, store_data);
      wmask_d  = store_mask(func3, result_i[1:0]);
      we_d     = is_store;
      lane_d   = result_i[1:0];
      f3_d     = func3;
      dest_d   = dest_i;
      alu_wb_d = !is_mem;
      err_d    = is_mem && !legal;
    end else if (in_req && mem_ack && !we_q) begin
      data_d = mem_rdata;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      we_q     <= 1'b0;
      lane_q   <= '0;
      f3_q     <= '0;
      dest_q   <= '0;
      alu_wb_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      we_q     <= we_d;
      lane_q   <= lane_d;
      f3_q     <= f3_d;
      dest_q   <= dest_d;
      alu_wb_q <= alu_wb_d;
      err_q    <= err_d;
    end
  end

  load_align u_load_align (
    .word_i  (data_q),
    .lane_i  (lane_q),
    .func3_i (f3_q),
    .data_o  (load_data)
  );

  // Bus outputs are gated by state so nothing stale leaks outside a request
  assign stall_o   = (state_q != ST_IDLE);
  assign mem_req   = in_req;
  assign mem_we    = in_req & we_q;
  assign mem_addr  = in_req ? {data_q[XLEN-1:2], 2'b00} : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;
  assign mem_wmask = mem_we ? wmask_q : '0;
  assign mem_err   = err_q;

  assign wb_valid  = alu_wb_q | in_resp;
  assign wb_data   = in_resp ? load_data : (alu_wb_q ? data_q : '0);
  assign dest_o    = wb_valid ? dest_q : '0;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed and randomized bench for mem_access against a behavioural model
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        is_load;
  logic        is_store;
  logic [2:0]  func3;
  logic [31:0] result_i;
  logic [31:0] store_data;
  logic [4:0]  dest_i;
  logic        stall_o;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  dest_o;
  logic        mem_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_access dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .is_load    (is_load),
    .is_store   (is_store),
    .func3      (func3),
    .result_i   (result_i),
    .store_data (store_data),
    .dest_i     (dest_i),
    .stall_o    (stall_o),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .dest_o     (dest_o),
    .mem_err    (mem_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Access size in bytes implied by func3
  function automatic int ref_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit ref_legal(input logic ld, input logic st, input logic [2:0] f3, input logic [1:0] a);
    if (ld == st) return 1'b0;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (st && f3 > 3'd2) return 1'b0;
    return (int'(a) % ref_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
    longint v;
    int     sz;
    sz = ref_size(f3);
    v  = longint'(w >> (8 * int'(a))) & ((64'd1 << (8 * sz)) - 64'd1);
    if (!f3[2] && sz < 4 && v >= longint'(64'd1 << (8 * sz - 1))) v = v - longint'(64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i] = (i >= int'(a)) && (i < int'(a) + ref_size(f3));
    return m;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % ref_size(f3)) +: 8];
    return r;
  endfunction

  // Issue one op and check every cycle until the block is idle again
  task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] d,
                        input logic [31:0] rd, input int nwait);
    valid_i    = 1'b1;
    is_load    = ld;
    is_store   = st;
    func3      = f3;
    result_i   = a;
    store_data = sd;
    dest_i     = d;
    step();
    valid_i = 1'b0;
    if (!ld && !st) begin
      chk({tag, ".wb_valid"}, wb_valid, 1);
      chk({tag, ".wb_data"},  wb_data,  a);
      chk({tag, ".dest_o"},   dest_o,   d);
      chk({tag, ".mem_req"},  mem_req,  0);
      chk({tag, ".stall_o"},  stall_o,  0);
      step();
      chk({tag, ".wb_valid_end"}, wb_valid, 0);
    end else if (!ref_legal(ld, st, f3, a[1:0])) begin
      chk({tag, ".mem_err"},  mem_err,  1);
      chk({tag, ".mem_req"},  mem_req,  0);
      chk({tag, ".stall_o"},  stall_o,  0);
      chk({tag, ".wb_valid"}, wb_valid, 0);
      step();
      chk({tag, ".mem_err_end"}, mem_err, 0);
      chk({tag, ".mem_req_end"}, mem_req, 0);
      chk({tag, ".stall_end"},   stall_o, 0);
    end else begin
      for (int k = 0; k <= nwait; k++) begin
        chk({tag, ".mem_req"},  mem_req,  1);
        chk({tag, ".stall_o"},  stall_o,  1);
        chk({tag, ".mem_addr"}, mem_addr, a & 32'hFFFF_FFFC);
        chk({tag, ".mem_we"},   mem_we,   st);
        chk({tag, ".wb_valid"}, wb_valid, 0);
        chk({tag, ".dest_o0"},  dest_o,   0);
        if (st) begin
          chk({tag, ".mem_wmask"}, mem_wmask, ref_mask(f3, a[1:0]));
          chk({tag, ".mem_wdata"}, mem_wdata, ref_wdata(f3, sd));
        end
        valid_i   = (k < nwait) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_ack   = (k == nwait);
        mem_rdata = (k == nwait) ? rd : $urandom;
        step();
      end
      mem_ack = 1'b0;
      valid_i = 1'b0;
      if (ld) begin
        chk({tag, ".ld_wb_valid"}, wb_valid, 1);
        chk({tag, ".ld_wb_data"},  wb_data,  ref_load(rd, a[1:0], f3));
        chk({tag, ".ld_dest_o"},   dest_o,   d);
        chk({tag, ".ld_mem_req"},  mem_req,  0);
        chk({tag, ".ld_stall_o"},  stall_o,  1);
        step();
      end
      chk({tag, ".end_wb_valid"}, wb_valid, 0);
      chk({tag, ".end_stall_o"},  stall_o,  0);
      chk({tag, ".end_mem_req"},  mem_req,  0);
      chk({tag, ".end_dest_o"},   dest_o,   0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall_o"},   stall_o,   0);
    chk({tag, ".wb_valid"},  wb_valid,  0);
    chk({tag, ".wb_data"},   wb_data,   0);
    chk({tag, ".dest_o"},    dest_o,    0);
    chk({tag, ".mem_err"},   mem_err,   0);
    chk({tag, ".mem_req"},   mem_req,   0);
    chk({tag, ".mem_we"},    mem_we,    0);
    chk({tag, ".mem_addr"},  mem_addr,  0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".mem_wmask"}, mem_wmask, 0);
  endtask

  initial begin
    reset      = 1'b1;
    valid_i    = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    func3      = '0;
    result_i   = '0;
    store_data = '0;
    dest_i     = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    run_op("alu",      1'b0, 1'b0, 3'b000, 32'd1234,      32'h0,         5'd7,  32'h0,         0);
    run_op("lb_103",   1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         5'd9,  32'h80FF_1234, 2);
    run_op("lhu_102",  1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,         5'd3,  32'hBEEF_0000, 1);
    run_op("sh_202",   1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd4,  32'h0,         0);
    run_op("lw_301",   1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'h0,         5'd5,  32'h0,         0);
    run_op("ld_bad",   1'b1, 1'b0, 3'b011, 32'h0000_0300, 32'h0,         5'd5,  32'h0,         0);
    run_op("ld_st",    1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h0,         5'd5,  32'h0,         0);
    run_op("lw_x0",    1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0,         5'd0,  32'hCAFE_F00D, 1);
    run_op("sb_3",     1'b0, 1'b1, 3'b000, 32'h0000_0603, 32'h1234_5678, 5'd2,  32'h0,         3);

    // Reset while a load waits for its ack, then a late ack must do nothing
    valid_i  = 1'b1;
    is_load  = 1'b1;
    is_store = 1'b0;
    func3    = 3'b010;
    result_i = 32'h0000_0400;
    dest_i   = 5'd11;
    step();
    valid_i = 1'b0;
    chk("rst_req.mem_req", mem_req, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all_zero("rst_req");
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_2222;
    step();
    step();
    mem_ack = 1'b0;
    chk("rst_late.wb_valid", wb_valid, 0);
    chk("rst_late.mem_req",  mem_req,  0);
    chk("rst_late.stall_o",  stall_o,  0);

    for (int n = 0; n < 80; n++) begin
      int          kind;
      logic        ld;
      logic        st;
      kind = $urandom_range(0, 9);
      ld   = (kind >= 2 && kind <= 5) || kind == 9;
      st   = (kind >= 6);
      run_op("rnd", ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom,
             5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
